// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control slice.
//   - Opcode and funct values decoded in ID.
//   - Forward-select encodings driven to the EX operand muxes.
//   - Tracker entry describing the destination of an in-flight instruction.
//   - Hazard FSM states.
package mips_pkg;

   localparam logic [5:0] ALUop   = 6'h00;
   localparam logic [5:0] Jop     = 6'h02;
   localparam logic [5:0] JALop   = 6'h03;
   localparam logic [5:0] ADD_IMM = 6'h08;
   localparam logic [5:0] LW      = 6'h23;
   localparam logic [5:0] SW      = 6'h2B;

   localparam logic [5:0] FUNCT_MULT = 6'h18;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   typedef struct packed {
      logic       vld;
      logic [4:0] dest;
      logic       is_load;
   } trk_t;

   typedef enum logic {RUN, MUL_BUSY} state_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational forward-select for one source register.
//   src               : source register read by the ID instruction
//   ex_vld/ex_dest    : tracker of the instruction currently in EX
//   mem_vld/mem_dest  : tracker of the instruction currently in MEM
//   sel               : FWD_EXMEM, FWD_MEMWB or FWD_REG
// Sampled while the consumer is still in ID, so the EX producer will sit in
// MEM (EXMEMALUOut) and the MEM producer in WB (MEMWBValue) once the consumer
// reaches EX. The newer producer wins; r0 is never forwarded.
module fwd_match
   import mips_pkg::*;
(
   input  logic [4:0] src,
   input  logic       ex_vld,
   input  logic [4:0] ex_dest,
   input  logic       mem_vld,
   input  logic [4:0] mem_dest,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_REG;
      if (ex_vld && (ex_dest != 5'd0) && (ex_dest == src))
         sel = FWD_EXMEM;
      else if (mem_vld && (mem_dest != 5'd0) && (mem_dest == src))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage operand muxes.
//   clock, reset_n      : pipeline clock, asynchronous active-low reset
//   id_valid, id_op,
//   id_funct, id_rs,
//   id_rt, id_rd        : instruction currently in ID
//   flush               : squash the ID instruction (taken jump/branch)
//   stall               : hold PC and IF/ID (combinational)
//   ex_bubble           : load a NOP into ID/EX this edge (combinational)
//   ex_hold             : ID/EX keeps its contents this edge (combinational)
//   mul_busy            : registered, high while a multi-cycle MULT occupies EX
//   fa, fb              : registered ALU A/B forward selects
module fwd_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       id_valid,
   input  logic [5:0] id_op,
   input  logic [5:0] id_funct,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       flush,
   output logic       stall,
   output logic       ex_bubble,
   output logic       ex_hold,
   output logic       mul_busy,
   output logic [1:0] fa,
   output logic [1:0] fb
);

   localparam logic [3:0] CNT_LOAD = 4'(MULT_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   // trk_p0 = EX, trk_p1 = MEM, trk_p2 = WB
   trk_t       trk_p0, trk_p1, trk_p2;
   trk_t       id_entry;

   logic       id_live;
   logic       id_dest_vld;
   logic [4:0] id_dest;
   logic       reads_rs, reads_rt;
   logic       load_use, mult_enter;
   logic [1:0] sel_a, sel_b;
   logic       unused_trk;

   assign id_live = id_valid && !flush;

   always_comb begin
      id_dest_vld = 1'b0;
      id_dest     = 5'd0;
      case (id_op)
         ALUop:       begin id_dest_vld = 1'b1; id_dest = id_rd;  end
         LW, ADD_IMM: begin id_dest_vld = 1'b1; id_dest = id_rt;  end
         JALop:       begin id_dest_vld = 1'b1; id_dest = 5'd31; end
         default:     ;
      endcase
      reads_rs = (id_op == ALUop) || (id_op == LW) || (id_op == SW) || (id_op == ADD_IMM);
      reads_rt = (id_op == ALUop) || (id_op == SW);

      // Writes to r0 are never tracked, so they can neither forward nor stall.
      id_entry.vld     = id_live && id_dest_vld && (id_dest != 5'd0);
      id_entry.dest    = id_dest;
      id_entry.is_load = (id_op == LW);
   end

   fwd_match u_match_rs (
      .src      (id_rs),
      .ex_vld   (trk_p0.vld),
      .ex_dest  (trk_p0.dest),
      .mem_vld  (trk_p1.vld),
      .mem_dest (trk_p1.dest),
      .sel      (sel_a)
   );

   fwd_match u_match_rt (
      .src      (id_rt),
      .ex_vld   (trk_p0.vld),
      .ex_dest  (trk_p0.dest),
      .mem_vld  (trk_p1.vld),
      .mem_dest (trk_p1.dest),
      .sel      (sel_b)
   );

   // A load in EX cannot supply its data until MEM completes, so a reader in
   // ID must wait one cycle and then take it from MEMWBValue.
   assign load_use = (state == RUN) && id_live && trk_p0.vld && trk_p0.is_load &&
                     ((reads_rs && (trk_p0.dest == id_rs)) ||
                      (reads_rt && (trk_p0.dest == id_rt)));

   assign mult_enter = id_live && !load_use && (id_op == ALUop) &&
                       (id_funct == FUNCT_MULT) && (MULT_CYCLES > 1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      ex_bubble = 1'b0;
      ex_hold   = 1'b0;
      case (state)
         RUN: begin
            if (load_use) begin
               stall     = 1'b1;
               ex_bubble = 1'b1;
            end else if (flush) begin
               ex_bubble = 1'b1;
            end
            if (mult_enter) begin
               state_nxt = MUL_BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         MUL_BUSY: begin
            stall   = 1'b1;
            ex_hold = 1'b1;
            cnt_nxt = cnt - 4'd1;
            // Leaving here still holds EX once more, giving MULT_CYCLES in EX.
            if (cnt == 4'd1)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign mul_busy = (state == MUL_BUSY);

   // ID -> EX boundary: trackers and forward selects
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         trk_p0 <= '0;
         trk_p1 <= '0;
         trk_p2 <= '0;
         fa     <= FWD_REG;
         fb     <= FWD_REG;
      end else if (ex_hold) begin
         // EX keeps the MULT; the slot behind it in MEM drains as a bubble.
         trk_p1 <= '0;
         trk_p2 <= trk_p1;
      end else begin
         trk_p0 <= ex_bubble ? trk_t'('0) : id_entry;
         trk_p1 <= trk_p0;
         trk_p2 <= trk_p1;
         if (ex_bubble || !id_live || (id_op != ALUop)) begin
            fa <= FWD_REG;
            fb <= FWD_REG;
         end else begin
            fa <= sel_a;
            fb <= sel_b;
         end
      end
   end

   // WB results reach readers through the write-before-read regfile, so the
   // WB tracker and the load flag beyond EX never steer a select.
   assign unused_trk = ^{trk_p2, trk_p1.is_load};

endmodule
